segre_mem_arbiter: RTL and testbench
====================================

Name: segre_mem_arbiter

Overview:
- Shares the single line-wide main-memory port between the instruction-cache miss path (IC) and the data-cache miss path (DC).
- For DC, it also sequences a dirty-line writeback ahead of the fill.
- Sits between the IF/TL stage miss logic and the memory model.
- Arbitrates round-robin, runs one transaction at a time, and returns the filled line with a one-cycle ready pulse.

Parameters:
ADDR_SIZE  32  byte address width
LANE_SIZE  128  cache line width in bits; line offset OFF = log2(LANE_SIZE/8) = 4

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
ic_req_i  in  1  IC miss request; held high until ic_rdy_o
ic_addr_i  in  ADDR_SIZE  IC miss byte address
ic_rdy_o  out  1  one-cycle pulse: ic_data_o valid
ic_data_o  out  LANE_SIZE  filled line for IC
dc_req_i  in  1  DC miss request; held high until dc_rdy_o
dc_addr_i  in  ADDR_SIZE  DC miss byte address
dc_wb_i  in  1  victim line dirty, write back first; sampled with dc_req_i at grant
dc_wb_addr_i  in  ADDR_SIZE  victim byte address
dc_wb_data_i  in  LANE_SIZE  victim line
dc_rdy_o  out  1  one-cycle pulse: dc_data_o valid
dc_data_o  out  LANE_SIZE  filled line for DC
mem_rd_o  out  1  one-cycle read command pulse
mem_wr_o  out  1  one-cycle write command pulse
mem_addr_o  out  ADDR_SIZE  line-aligned address (low OFF bits zero)
mem_wdata_o  out  LANE_SIZE  write data
mem_valid_i  in  1  memory completion: read data valid, or write acknowledged
mem_rdata_i  in  LANE_SIZE  read data
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - State = IDLE; all outputs 0.
  - last_grant = IC, so DC wins the first tie.
  - Grant and latched request registers are cleared.
- Reset mid-transaction: abandon the transaction and return to IDLE next cycle. A late mem_valid_i after reset is ignored.
- States: IDLE, WB_CMD, WB_WAIT, RD_CMD, RD_WAIT, RESP.
- IDLE arbitration:
  - Only one request high: grant it.
  - Both high: grant the requester that is not last_grant.
  - On grant, latch the requester id, line-aligned fill address, dc_wb_i, wb address and wb data, and update last_grant.
  - Go to WB_CMD if DC is granted with dc_wb_i=1; otherwise go to RD_CMD.
  - No request: stay in IDLE.
- WB_CMD (1 cycle): mem_wr_o=1, mem_addr_o = latched wb address with low OFF bits zeroed, mem_wdata_o = latched data. Go to WB_WAIT.
- WB_WAIT: hold until mem_valid_i=1, then go to RD_CMD.
- RD_CMD (1 cycle): mem_rd_o=1, mem_addr_o = latched fill address with low OFF bits zeroed. Go to RD_WAIT.
- RD_WAIT: on mem_valid_i=1, capture mem_rdata_i into the granted requester's data register and go to RESP.
- RESP (1 cycle):
  - Assert ic_rdy_o or dc_rdy_o for the granted requester only; the data output holds the captured line.
  - Return to IDLE.
  - The requester must deassert req in the cycle after rdy. IDLE does not regrant in the RESP cycle itself.
- Latency: with memory latency L (mem_valid_i L cycles after the command), a read-only miss has req-to-rdy = 1 (IDLE) + 1 + L + 1 cycles.
- Writeback ordering: the writeback is always acknowledged before the fill read is issued, so a same-line writeback followed by its fill returns the written data.
- mem_valid_i outside WB_WAIT/RD_WAIT: ignored.
- mem_rd_o and mem_wr_o are never high together; each is high for exactly one cycle per transaction.
- ic_data_o and dc_data_o retain their last captured line; they are only meaningful while the matching rdy is high.
- Requests arriving or changing while busy are not sampled. Address and wb inputs are used only as latched at grant.
- No starvation: with both requests held continuously, grants strictly alternate.

Test Plan:
- IC read only: ic_req_i=1, ic_addr_i=0x0000_1234; memory returns 0xAA..AA after L=3. Expect one mem_rd_o pulse with mem_addr_o=0x0000_1230, then ic_rdy_o for one cycle with ic_data_o=0xAA..AA, 6 cycles after req; dc_rdy_o stays 0.
- DC dirty miss: dc_req_i=1, dc_wb_i=1, dc_wb_addr_i=0x80, dc_wb_data_i=0x11..11, dc_addr_i=0x84. Expect mem_wr_o at 0x80 with 0x11..11, then mem_rd_o at 0x80 only after the write ack; dc_data_o returns 0x11..11.
- Tie from reset: ic_req_i and dc_req_i both asserted in the same cycle. Expect DC served first, then IC.
- Continuous contention: both requests held for 4 transactions. Expect grant order DC, IC, DC, IC.
- Reset mid-operation: assert rst_i during RD_WAIT, then inject mem_valid_i the next cycle. Expect no rdy pulse, busy_o=0, and all outputs 0.
- Back-to-back: IC drops req after rdy while DC is pending. Expect the DC grant in the IDLE cycle following RESP, with no overlapping mem commands.

Source files
------------

// File: rtl/segre_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the IC and DC miss paths.
// DC misses with a dirty victim write the victim back before the fill read is issued.
module segre_mem_arbiter #(
   parameter int ADDR_SIZE = 32,
   parameter int LANE_SIZE = 128
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 ic_req_i,
   input  logic [ADDR_SIZE-1:0] ic_addr_i,
   output logic                 ic_rdy_o,
   output logic [LANE_SIZE-1:0] ic_data_o,
   input  logic                 dc_req_i,
   input  logic [ADDR_SIZE-1:0] dc_addr_i,
   input  logic                 dc_wb_i,
   input  logic [ADDR_SIZE-1:0] dc_wb_addr_i,
   input  logic [LANE_SIZE-1:0] dc_wb_data_i,
   output logic                 dc_rdy_o,
   output logic [LANE_SIZE-1:0] dc_data_o,
   output logic                 mem_rd_o,
   output logic                 mem_wr_o,
   output logic [ADDR_SIZE-1:0] mem_addr_o,
   output logic [LANE_SIZE-1:0] mem_wdata_o,
   input  logic                 mem_valid_i,
   input  logic [LANE_SIZE-1:0] mem_rdata_i,
   output logic                 busy_o
);

   localparam int OFF = $clog2(LANE_SIZE/8);
   localparam logic [ADDR_SIZE-1:0] LINE_MASK = ~((ADDR_SIZE)'((1 << OFF) - 1));

   typedef enum logic [2:0] {IDLE, WB_CMD, WB_WAIT, RD_CMD, RD_WAIT, RESP} state_t;

   state_t               state;
   logic                 last_dc;   // last grant went to DC; reset value favours DC on the first tie
   logic                 gnt_dc;
   logic [ADDR_SIZE-1:0] fill_addr;
   logic                 pick_dc;
   logic [ADDR_SIZE-1:0] pick_addr;

   assign pick_dc   = dc_req_i && (!ic_req_i || !last_dc);
   assign pick_addr = (pick_dc ? dc_addr_i : ic_addr_i) & LINE_MASK;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         last_dc     <= 1'b0;
         gnt_dc      <= 1'b0;
         fill_addr   <= '0;
         ic_rdy_o    <= 1'b0;
         ic_data_o   <= '0;
         dc_rdy_o    <= 1'b0;
         dc_data_o   <= '0;
         mem_rd_o    <= 1'b0;
         mem_wr_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         busy_o      <= 1'b0;
      end else begin
         mem_rd_o <= 1'b0;
         mem_wr_o <= 1'b0;
         ic_rdy_o <= 1'b0;
         dc_rdy_o <= 1'b0;
         case (state)
            IDLE: begin
               if (ic_req_i || dc_req_i) begin
                  gnt_dc    <= pick_dc;
                  last_dc   <= pick_dc;
                  fill_addr <= pick_addr;
                  busy_o    <= 1'b1;
                  // Command outputs are registered, so the writeback payload is latched straight into them.
                  if (pick_dc && dc_wb_i) begin
                     state       <= WB_CMD;
                     mem_wr_o    <= 1'b1;
                     mem_addr_o  <= dc_wb_addr_i & LINE_MASK;
                     mem_wdata_o <= dc_wb_data_i;
                  end else begin
                     state      <= RD_CMD;
                     mem_rd_o   <= 1'b1;
                     mem_addr_o <= pick_addr;
                  end
               end
            end
            WB_CMD: begin
               mem_addr_o  <= '0;
               mem_wdata_o <= '0;
               state       <= WB_WAIT;
            end
            WB_WAIT: begin
               if (mem_valid_i) begin
                  state      <= RD_CMD;
                  mem_rd_o   <= 1'b1;
                  mem_addr_o <= fill_addr;
               end
            end
            RD_CMD: begin
               mem_addr_o <= '0;
               state      <= RD_WAIT;
            end
            RD_WAIT: begin
               if (mem_valid_i) begin
                  if (gnt_dc) dc_data_o <= mem_rdata_i;
                  else        ic_data_o <= mem_rdata_i;
                  ic_rdy_o <= !gnt_dc;
                  dc_rdy_o <= gnt_dc;
                  state    <= RESP;
               end
            end
            RESP: begin
               busy_o <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Bench for segre_mem_arbiter: directed scenarios then random traffic, checked against a
// transaction-level memory/arbitration model that observes the memory port and rdy pulses.
module tb_segre_mem_arbiter;

   localparam logic [31:0] LMASK = 32'hFFFF_FFF0;

   logic         clk = 1'b0;
   logic         rst_i;
   logic         ic_req_i, dc_req_i, dc_wb_i;
   logic [31:0]  ic_addr_i, dc_addr_i, dc_wb_addr_i;
   logic [127:0] dc_wb_data_i;
   logic         ic_rdy_o, dc_rdy_o, mem_rd_o, mem_wr_o, busy_o;
   logic [127:0] ic_data_o, dc_data_o, mem_wdata_o;
   logic [31:0]  mem_addr_o;
   logic         mem_valid_i;
   logic [127:0] mem_rdata_i = '0;
   logic         mdl_valid = 1'b0;
   logic         inj_valid = 1'b0;

   assign mem_valid_i = mdl_valid | inj_valid;

   segre_mem_arbiter #(.ADDR_SIZE(32), .LANE_SIZE(128)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_rdy_o(ic_rdy_o), .ic_data_o(ic_data_o),
      .dc_req_i(dc_req_i), .dc_addr_i(dc_addr_i), .dc_wb_i(dc_wb_i),
      .dc_wb_addr_i(dc_wb_addr_i), .dc_wb_data_i(dc_wb_data_i),
      .dc_rdy_o(dc_rdy_o), .dc_data_o(dc_data_o),
      .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_valid_i(mem_valid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;
   int lat      = 3;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference memory: unwritten lines read back as an address-derived pattern.
   logic [127:0] mem_model [logic [31:0]];

   function automatic logic [127:0] mem_rd(input logic [31:0] a);
      return mem_model.exists(a) ? mem_model[a] : {4{a ^ 32'h5A5A_0000}};
   endfunction

   // Transaction model state
   int           pend_cnt = 0;
   logic         pend_wr;
   logic [31:0]  pend_addr;
   logic [127:0] pend_data, rd_val;
   logic         txn_act = 1'b0, last_dc_m = 1'b0;
   logic         t_dc, t_wb, t_wr_done, t_wr_ack, t_rd_done, rd_fired;
   logic [31:0]  t_fill, t_wb_addr, last_rd_addr, last_wr_addr;
   logic [127:0] t_wb_data;
   logic         prev_ic, prev_dc, prev_wb;
   logic [31:0]  prev_ic_addr, prev_dc_addr, prev_wb_addr;
   logic [127:0] prev_wb_data;
   int           rd_pulses = 0, wr_pulses = 0, rdy_cnt = 0;

   always @(negedge clk) begin
      if (rst_i) begin
         pend_cnt  = 0;
         mdl_valid = 1'b0;
         txn_act   = 1'b0;
         last_dc_m = 1'b0;
      end else begin
         chk("busy", 128'(busy_o), 128'(txn_act || mem_rd_o || mem_wr_o));
         chk("rd_wr_excl", 128'(mem_rd_o & mem_wr_o), 128'(0));
         if ((mem_rd_o || mem_wr_o) && !txn_act) begin
            // A new transaction: the grant was decided on the requests seen in the previous cycle.
            chk("grant_has_req", 128'(prev_ic | prev_dc), 128'(1));
            t_dc      = prev_dc && (!prev_ic || !last_dc_m);
            last_dc_m = t_dc;
            txn_act   = 1'b1;
            t_fill    = (t_dc ? prev_dc_addr : prev_ic_addr) & LMASK;
            t_wb      = t_dc && prev_wb;
            t_wb_addr = prev_wb_addr & LMASK;
            t_wb_data = prev_wb_data;
            t_wr_done = 1'b0; t_wr_ack = 1'b0; t_rd_done = 1'b0; rd_fired = 1'b0;
         end
         if (mem_wr_o) begin
            wr_pulses++;
            last_wr_addr = mem_addr_o;
            chk("wr_expected", 128'(t_wb && !t_wr_done), 128'(1));
            chk("wr_addr", 128'(mem_addr_o), 128'(t_wb_addr));
            chk("wr_data", mem_wdata_o, t_wb_data);
            t_wr_done = 1'b1;
         end
         if (mem_rd_o) begin
            rd_pulses++;
            last_rd_addr = mem_addr_o;
            chk("rd_order", 128'(!t_rd_done && (!t_wb || t_wr_ack)), 128'(1));
            chk("rd_addr", 128'(mem_addr_o), 128'(t_fill));
            t_rd_done = 1'b1;
         end
         if (ic_rdy_o || dc_rdy_o) begin
            chk("rdy_in_txn", 128'(txn_act && t_rd_done && rd_fired), 128'(1));
            chk("rdy_sel", 128'({ic_rdy_o, dc_rdy_o}), 128'({!t_dc, t_dc}));
            chk("rdy_data", t_dc ? dc_data_o : ic_data_o, rd_val);
            txn_act = 1'b0;
            rdy_cnt++;
         end
         mdl_valid = 1'b0;
         if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               mdl_valid = 1'b1;
               if (pend_wr) begin
                  mem_model[pend_addr] = pend_data;
                  t_wr_ack = 1'b1;
               end else begin
                  rd_val      = mem_rd(pend_addr);
                  mem_rdata_i = rd_val;
                  rd_fired    = 1'b1;
               end
            end
         end
         if (mem_rd_o || mem_wr_o) begin
            pend_cnt  = lat;
            pend_wr   = mem_wr_o;
            pend_addr = mem_addr_o;
            pend_data = mem_wdata_o;
         end
      end
      prev_ic = ic_req_i; prev_dc = dc_req_i; prev_wb = dc_wb_i;
      prev_ic_addr = ic_addr_i; prev_dc_addr = dc_addr_i;
      prev_wb_addr = dc_wb_addr_i; prev_wb_data = dc_wb_data_i;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns at the negedge of the first rdy cycle; n counts the cycles before it.
   task automatic wait_any(output bit got_dc, output int n);
      got_dc = 1'b0;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ic_rdy_o || dc_rdy_o) begin
            got_dc = dc_rdy_o;
            return;
         end
         n++;
      end
      chk("rdy_within_budget", 128'(n), 128'(0));
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, 128'({ic_rdy_o, dc_rdy_o, mem_rd_o, mem_wr_o, busy_o}), 128'(0));
      chk({tag, "_addr"}, 128'(mem_addr_o), 128'(0));
      chk({tag, "_wdata"}, mem_wdata_o, 128'(0));
      chk({tag, "_data"}, ic_data_o | dc_data_o, 128'(0));
   endtask

   bit gd, exp_dc, is_r, ds_r;
   int n, n2, rp0, wp0;

   initial begin
      rst_i = 1'b1;
      ic_req_i = 1'b0; dc_req_i = 1'b0; dc_wb_i = 1'b0;
      ic_addr_i = '0; dc_addr_i = '0; dc_wb_addr_i = '0; dc_wb_data_i = '0;
      mem_model[32'h0000_1230] = {16{8'hAA}};
      repeat (3) tick();
      chk_zero("reset");
      rst_i = 1'b0;
      tick();

      // IC read-only miss
      ic_req_i = 1'b1; ic_addr_i = 32'h0000_1234; rp0 = rd_pulses;
      wait_any(gd, n);
      chk("t1_who", 128'(gd), 128'(0));
      chk("t1_latency", 128'(n), 128'(5));
      chk("t1_data", ic_data_o, {16{8'hAA}});
      chk("t1_dc_rdy", 128'(dc_rdy_o), 128'(0));
      chk("t1_rd_pulses", 128'(rd_pulses - rp0), 128'(1));
      chk("t1_rd_addr", 128'(last_rd_addr), 128'(32'h0000_1230));
      tick();
      ic_req_i = 1'b0;

      // DC dirty miss: writeback to the same line precedes the fill
      dc_req_i = 1'b1; dc_wb_i = 1'b1; dc_addr_i = 32'h84;
      dc_wb_addr_i = 32'h80; dc_wb_data_i = {4{32'h1111_1111}};
      rp0 = rd_pulses; wp0 = wr_pulses;
      wait_any(gd, n);
      chk("t2_who", 128'(gd), 128'(1));
      chk("t2_latency", 128'(n), 128'(9));
      chk("t2_data", dc_data_o, {4{32'h1111_1111}});
      chk("t2_wr_pulses", 128'(wr_pulses - wp0), 128'(1));
      chk("t2_rd_pulses", 128'(rd_pulses - rp0), 128'(1));
      chk("t2_wr_addr", 128'(last_wr_addr), 128'(32'h80));
      chk("t2_rd_addr", 128'(last_rd_addr), 128'(32'h80));
      tick();
      dc_req_i = 1'b0; dc_wb_i = 1'b0;

      // Tie straight out of reset: DC first
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      ic_req_i = 1'b1; ic_addr_i = 32'h2000;
      dc_req_i = 1'b1; dc_addr_i = 32'h3000;
      wait_any(gd, n);
      chk("t3_first_dc", 128'(gd), 128'(1));
      tick();
      dc_req_i = 1'b0;
      wait_any(gd, n);
      chk("t3_second_ic", 128'(gd), 128'(0));
      tick();
      ic_req_i = 1'b0;

      // Continuous contention alternates
      ic_req_i = 1'b1; dc_req_i = 1'b1; exp_dc = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_any(gd, n);
         chk("t4_order", 128'(gd), 128'(exp_dc));
         tick();
         if (gd) dc_req_i = 1'b0; else ic_req_i = 1'b0;
         if (k < 3) begin
            tick();
            if (gd) dc_req_i = 1'b1; else ic_req_i = 1'b1;
         end
         exp_dc = !exp_dc;
      end
      wait_any(gd, n);
      chk("t4_tail_dc", 128'(gd), 128'(1));
      tick();
      dc_req_i = 1'b0;

      // Reset during RD_WAIT, late mem_valid afterwards
      ic_req_i = 1'b1; ic_addr_i = 32'h4000;
      n2 = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (mem_rd_o) break;
         n2++;
      end
      chk("t5_rd_seen", 128'(mem_rd_o), 128'(1));
      tick();
      rst_i = 1'b1; ic_req_i = 1'b0;
      tick();
      rst_i = 1'b0; inj_valid = 1'b1;
      @(negedge clk);
      chk_zero("t5_after_rst");
      tick();
      inj_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_quiet", 128'({ic_rdy_o, dc_rdy_o, busy_o}), 128'(0));
      end
      tick();

      // Back-to-back: DC pending while IC is served
      ic_req_i = 1'b1; ic_addr_i = 32'h5010;
      tick();
      dc_req_i = 1'b1; dc_addr_i = 32'h6020;
      wait_any(gd, n);
      chk("t6_first_ic", 128'(gd), 128'(0));
      tick();
      ic_req_i = 1'b0;
      n2 = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_rd_o || mem_wr_o) break;
         n2++;
      end
      chk("t6_gap", 128'(n2), 128'(1));
      wait_any(gd, n);
      chk("t6_second_dc", 128'(gd), 128'(1));
      tick();
      dc_req_i = 1'b0;

      // Random traffic
      rp0 = rdy_cnt;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         @(negedge clk);
         is_r = ic_rdy_o; ds_r = dc_rdy_o;
         tick();
         lat = int'($urandom_range(1, 4));
         if (is_r) ic_req_i = 1'b0;
         else if (!ic_req_i && $urandom_range(0, 2) == 0) begin
            ic_req_i = 1'b1;
            ic_addr_i = {16'h0001, 16'($urandom)};
         end
         if (ds_r) dc_req_i = 1'b0;
         else if (!dc_req_i && $urandom_range(0, 2) == 0) begin
            dc_req_i = 1'b1;
            dc_addr_i = {16'h0002, 8'h00, 8'($urandom)};
            dc_wb_i = 1'($urandom);
            dc_wb_addr_i = ($urandom_range(0, 1) == 0) ? dc_addr_i : {16'h0002, 8'h00, 8'($urandom)};
            dc_wb_data_i = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      for (int i = 0; i < 200 && (ic_req_i || dc_req_i); i++) begin
         @(negedge clk);
         is_r = ic_rdy_o; ds_r = dc_rdy_o;
         tick();
         if (is_r) ic_req_i = 1'b0;
         if (ds_r) dc_req_i = 1'b0;
      end
      chk("rand_drain", 128'({ic_req_i, dc_req_i}), 128'(0));
      chk("rand_progress", 128'(rdy_cnt - rp0 > 50), 128'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not complete, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
